dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
Two-master arbiter for the shared 1 KB data memory (dm_1k). Master 0 is the CPU datapath (address from ALU output register, store data from B register). Master 1 is the loader/debug port that fills or inspects data memory while the CPU runs. The block serialises accesses with round-robin fairness. It also supports a locked read-then-write pair for sb byte merging, bounded by a starvation limit.

Parameters:
ADDR_W, 10, byte address width into dm_1k
DATA_W, 32, data word width
MAX_LOCK, 4, max consecutive locked transfers one master may take while the other is requesting

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
m0_req  input  1  master 0 request; held high until m0_ack
m0_we  input  1  master 0 write (1) / read (0)
m0_lock  input  1  master 0 keeps the grant for its next transfer
m0_addr  input  ADDR_W  master 0 address
m0_wdata  input  DATA_W  master 0 write data
m0_ack  output  1  one-cycle completion pulse to master 0
m0_rdata  output  DATA_W  registered read data for master 0
m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_ack, m1_rdata: same as m0_*, for master 1
mem_addr  output  ADDR_W  address to dm_1k
mem_wdata  output  DATA_W  write data to dm_1k
mem_wr  output  1  write enable to dm_1k
mem_rdata  input  DATA_W  combinational read data from dm_1k
gnt  output  2  one-hot current grant (bit0 = m0, bit1 = m1); 00 when idle
busy  output  1  high in ACCESS or DONE

Behaviour:
- Reset values: state IDLE, gnt=00, busy=0, m0_ack=m1_ack=0, m0_rdata=m1_rdata=0, last=1 (master 0 wins the first tie), lock_cnt=0, mem_wr=0.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE.
  - One requester: grant it, go to ACCESS.
  - Both requesting: grant the master not equal to last, go to ACCESS.
- ACCESS (one cycle):
  - mem_addr, mem_wdata and mem_wr are driven combinationally from the granted master's inputs.
  - mem_wr = granted we & ~rst.
  - At the clock edge, mem_rdata is captured into the granted master's rdata register, only when it is a read; the other master's rdata is unchanged.
  - last is updated to the granted master. Go to DONE.
- DONE (one cycle):
  - Granted master's ack is high for exactly this cycle. mem_wr=0.
  - If the granted master has req=1 and lock=1 in this cycle, and either lock_cnt<MAX_LOCK-1 or the other master has req=0: stay granted, increment lock_cnt (saturating), go to ACCESS.
  - Otherwise: lock_cnt=0, gnt=00, go to IDLE.
- Outside ACCESS: mem_addr=0, mem_wdata=0, mem_wr=0.
- Latency: request seen in IDLE at cycle N → memory access at N+1 → ack and valid rdata at N+2. Unlocked throughput is 1 transfer per 3 cycles; locked throughput is 1 per 2 cycles.
- Masters must hold req/we/addr/wdata stable from assertion through their ack cycle. A master that drops req during ACCESS does not abort the transfer; the write still commits and ack still pulses. Masters sample ack only.
- The lock flag is evaluated only in DONE; lock asserted in IDLE has no effect on arbitration.
- Starvation: with both masters requesting, a locked master gets at most MAX_LOCK consecutive transfers, then the grant passes to the other master (last already points at the locked master).
- Reset in any state returns to IDLE at that edge. A write in progress during a reset cycle does not commit (mem_wr is gated by rst), and no ack is issued.
- Address wrap is not handled here; addresses pass through unmodified.

Test Plan:
- Single read: dm[0x010]=0x12345678, m0 read 0x010 → gnt=01 at cycle 1, m0_ack pulse at cycle 2, m0_rdata=0x12345678, m1_rdata unchanged (0).
- Write then read by m1: m1 write 0x020←0xDEADBEEF, then read 0x020 → mem_wr high for exactly one cycle; m1_rdata=0xDEADBEEF; 6 cycles total.
- Tie after reset: m0 and m1 request together continuously → grants alternate m0,m1,m0,m1, each ack 3 cycles apart; no gaps beyond IDLE.
- Locked sb sequence: m0 read 0x030 with lock=1, then write 0x030 ←{old[31:8],8'hAB} → second ACCESS immediately follows DONE (2-cycle spacing), m1 request pending meanwhile is served right after.
- Starvation bound (MAX_LOCK=4): m0 holds req+lock permanently, m1 requests → exactly 4 consecutive m0 acks, then m1 ack, then m0 again.
- Reset mid-write: assert rst during ACCESS of an m1 write to 0x040 (old 0x0) → dm[0x040] stays 0x0, no m1_ack, next cycle gnt=00, busy=0, all outputs at reset values.

Source files
------------

// File: rtl/dm_arbiter.sv
// Two-master round-robin arbiter in front of the 1 KB data memory.
// Supports locked back-to-back transfers (sb read-modify-write) with a starvation bound.
module dm_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        gnt,
  output logic              busy
);

  localparam int CNT_W = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
  localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(MAX_LOCK - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e            state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

  logic              sel_m1;
  logic              g_req, g_we, g_lock, o_req;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;

  assign sel_m1  = gnt_q[1];
  assign g_req   = sel_m1 ? m1_req   : m0_req;
  assign g_we    = sel_m1 ? m1_we    : m0_we;
  assign g_lock  = sel_m1 ? m1_lock  : m0_lock;
  assign g_addr  = sel_m1 ? m1_addr  : m0_addr;
  assign g_wdata = sel_m1 ? m1_wdata : m0_wdata;
  assign o_req   = sel_m1 ? m0_req   : m1_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= 2'b00;
      last_q     <= 1'b1;
      lock_cnt_q <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    case (state_q)
      IDLE: begin
        // last_q==1 means m1 was served last, so m0 wins a tie
        if (m0_req && (!m1_req || last_q)) begin
          gnt_d   = 2'b01;
          state_d = ACCESS;
        end else if (m1_req) begin
          gnt_d   = 2'b10;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        state_d = DONE;
        last_d  = sel_m1;
        if (!g_we) begin
          if (sel_m1) m1_rdata_d = mem_rdata;
          else        m0_rdata_d = mem_rdata;
        end
      end
      DONE: begin
        if (g_req && g_lock && ((lock_cnt_q < LOCK_LIM) || !o_req)) begin
          state_d = ACCESS;
          if (lock_cnt_q != LOCK_LIM) lock_cnt_d = lock_cnt_q + 1'b1;
        end else begin
          state_d    = IDLE;
          gnt_d      = 2'b00;
          lock_cnt_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        gnt_d      = 2'b00;
        lock_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wr    = 1'b0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    busy      = (state_q == ACCESS) || (state_q == DONE);
    gnt       = gnt_q;
    m0_rdata  = m0_rdata_q;
    m1_rdata  = m1_rdata_q;
    if (state_q == ACCESS) begin
      mem_addr  = g_addr;
      mem_wdata = g_wdata;
      mem_wr    = g_we & ~rst;
    end
    if (state_q == DONE) begin
      m0_ack = gnt_q[0];
      m1_ack = gnt_q[1];
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed self-checking bench for dm_arbiter with a word-addressed memory model.
module tb_dm_arbiter;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              m0_req = 0, m0_we = 0, m0_lock = 0;
  logic [ADDR_W-1:0] m0_addr = '0;
  logic [DATA_W-1:0] m0_wdata = '0;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rdata;
  logic              m1_req = 0, m1_we = 0, m1_lock = 0;
  logic [ADDR_W-1:0] m1_addr = '0;
  logic [DATA_W-1:0] m1_wdata = '0;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        gnt;
  logic              busy;

  logic [DATA_W-1:0] tb_mem [0:255];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int wr_cycles = 0;
  int ack_who[$];
  int ack_cyc[$];
  int exp_who[$];
  int exp_cyc[$];

  dm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_LOCK(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .gnt(gnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // dm_1k model: combinational read, write on the rising edge
  assign mem_rdata = tb_mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_wr) tb_mem[mem_addr[9:2]] <= mem_wdata;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int m, input logic req, input logic we, input logic lock,
                               input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    if (m == 0) begin
      m0_req = req; m0_we = we; m0_lock = lock; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = req; m1_we = we; m1_lock = lock; m1_addr = addr; m1_wdata = wdata;
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
    cyc++;
    if (m0_ack) begin ack_who.push_back(0); ack_cyc.push_back(cyc); end
    if (m1_ack) begin ack_who.push_back(1); ack_cyc.push_back(cyc); end
    if (mem_wr) wr_cycles++;
  endtask

  task automatic startTest();
    cyc = 0;
    wr_cycles = 0;
    ack_who.delete();
    ack_cyc.delete();
  endtask

  task automatic verifyAcks(input string tag);
    checkOutput({tag, "_ack_count"}, 64'(ack_who.size()), 64'(exp_who.size()));
    for (int i = 0; i < exp_who.size(); i++) begin
      if (i < ack_who.size()) begin
        checkOutput($sformatf("%s_ack%0d_master", tag, i), 64'(ack_who[i]), 64'(exp_who[i]));
        checkOutput($sformatf("%s_ack%0d_cycle", tag, i), 64'(ack_cyc[i]), 64'(exp_cyc[i]));
      end
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    stepCycle();
    stepCycle();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) tb_mem[i] <= '0;
    #1;
    tb_mem[4]  <= 32'h1234_5678;
    tb_mem[12] <= 32'hCAFE_F00D;
    doReset();

    $display("[TB] reset state");
    checkOutput("rst_gnt", 64'(gnt), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_m0_ack", 64'(m0_ack), 64'd0);
    checkOutput("rst_m1_ack", 64'(m1_ack), 64'd0);
    checkOutput("rst_m0_rdata", 64'(m0_rdata), 64'd0);
    checkOutput("rst_m1_rdata", 64'(m1_rdata), 64'd0);
    checkOutput("rst_mem_wr", 64'(mem_wr), 64'd0);

    $display("[TB] single read by m0");
    startTest();
    applyStimulus(0, 1, 0, 0, 10'h010, '0);
    stepCycle();
    checkOutput("rd_gnt_c1", 64'(gnt), 64'b01);
    checkOutput("rd_busy_c1", 64'(busy), 64'd1);
    checkOutput("rd_addr_c1", 64'(mem_addr), 64'h010);
    checkOutput("rd_wr_c1", 64'(mem_wr), 64'd0);
    stepCycle();
    checkOutput("rd_m0_ack_c2", 64'(m0_ack), 64'd1);
    checkOutput("rd_m0_rdata", 64'(m0_rdata), 64'h1234_5678);
    checkOutput("rd_m1_rdata", 64'(m1_rdata), 64'd0);
    applyStimulus(0, 0, 0, 0, '0, '0);
    stepCycle();
    checkOutput("rd_gnt_c3", 64'(gnt), 64'd0);
    checkOutput("rd_m0_ack_c3", 64'(m0_ack), 64'd0);

    $display("[TB] write then read by m1");
    startTest();
    applyStimulus(1, 1, 1, 0, 10'h020, 32'hDEAD_BEEF);
    stepCycle();
    checkOutput("wr_mem_wr", 64'(mem_wr), 64'd1);
    checkOutput("wr_mem_addr", 64'(mem_addr), 64'h020);
    checkOutput("wr_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    checkOutput("wr_gnt", 64'(gnt), 64'b10);
    stepCycle();
    stepCycle();
    applyStimulus(1, 1, 0, 0, 10'h020, '0);
    stepCycle();
    stepCycle();
    checkOutput("wr_m1_rdata", 64'(m1_rdata), 64'hDEAD_BEEF);
    applyStimulus(1, 0, 0, 0, '0, '0);
    stepCycle();
    checkOutput("wr_busy_c6", 64'(busy), 64'd0);
    checkOutput("wr_cycles", 64'(wr_cycles), 64'd1);
    checkOutput("wr_mem_word", 64'(tb_mem[8]), 64'hDEAD_BEEF);
    exp_who = '{1, 1};
    exp_cyc = '{2, 5};
    verifyAcks("wr");

    $display("[TB] tie after reset");
    doReset();
    startTest();
    applyStimulus(0, 1, 0, 0, 10'h010, '0);
    applyStimulus(1, 1, 0, 0, 10'h020, '0);
    for (int i = 0; i < 12; i++) stepCycle();
    applyStimulus(0, 0, 0, 0, '0, '0);
    applyStimulus(1, 0, 0, 0, '0, '0);
    exp_who = '{0, 1, 0, 1};
    exp_cyc = '{2, 5, 8, 11};
    verifyAcks("tie");
    checkOutput("tie_m0_rdata", 64'(m0_rdata), 64'h1234_5678);
    checkOutput("tie_m1_rdata", 64'(m1_rdata), 64'hDEAD_BEEF);

    $display("[TB] locked sb sequence");
    startTest();
    applyStimulus(0, 1, 0, 1, 10'h030, '0);
    stepCycle();
    applyStimulus(1, 1, 0, 0, 10'h010, '0);
    stepCycle();
    checkOutput("sb_rd_m0_rdata", 64'(m0_rdata), 64'hCAFE_F00D);
    applyStimulus(0, 1, 1, 1, 10'h030, 32'hCAFE_F0AB);
    stepCycle();
    checkOutput("sb_wr_gnt", 64'(gnt), 64'b01);
    checkOutput("sb_wr_mem_wr", 64'(mem_wr), 64'd1);
    checkOutput("sb_wr_wdata", 64'(mem_wdata), 64'hCAFE_F0AB);
    applyStimulus(0, 1, 1, 0, 10'h030, 32'hCAFE_F0AB);
    stepCycle();
    applyStimulus(0, 0, 0, 0, '0, '0);
    stepCycle();
    stepCycle();
    checkOutput("sb_m1_gnt", 64'(gnt), 64'b10);
    stepCycle();
    checkOutput("sb_m1_rdata", 64'(m1_rdata), 64'h1234_5678);
    applyStimulus(1, 0, 0, 0, '0, '0);
    stepCycle();
    exp_who = '{0, 0, 1};
    exp_cyc = '{2, 4, 7};
    verifyAcks("sb");
    checkOutput("sb_mem_word", 64'(tb_mem[12]), 64'hCAFE_F0AB);

    $display("[TB] starvation bound");
    doReset();
    startTest();
    applyStimulus(0, 1, 0, 1, 10'h010, '0);
    applyStimulus(1, 1, 0, 0, 10'h020, '0);
    for (int i = 0; i < 14; i++) begin
      stepCycle();
      if (cyc == 11) applyStimulus(1, 0, 0, 0, '0, '0);
    end
    applyStimulus(0, 0, 0, 0, '0, '0);
    stepCycle();
    exp_who = '{0, 0, 0, 0, 1, 0};
    exp_cyc = '{2, 4, 6, 8, 11, 14};
    verifyAcks("starve");

    $display("[TB] reset during write");
    startTest();
    applyStimulus(1, 1, 1, 0, 10'h040, 32'h55AA_55AA);
    stepCycle();
    checkOutput("rw_mem_wr_pre", 64'(mem_wr), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("rw_mem_wr_gated", 64'(mem_wr), 64'd0);
    stepCycle();
    checkOutput("rw_gnt", 64'(gnt), 64'd0);
    checkOutput("rw_busy", 64'(busy), 64'd0);
    checkOutput("rw_m1_ack", 64'(m1_ack), 64'd0);
    checkOutput("rw_m0_rdata", 64'(m0_rdata), 64'd0);
    checkOutput("rw_m1_rdata", 64'(m1_rdata), 64'd0);
    checkOutput("rw_mem_addr", 64'(mem_addr), 64'd0);
    rst = 1'b0;
    applyStimulus(1, 0, 0, 0, '0, '0);
    stepCycle();
    checkOutput("rw_gnt_after", 64'(gnt), 64'd0);
    checkOutput("rw_mem_word", 64'(tb_mem[16]), 64'd0);
    checkOutput("rw_ack_count", 64'(ack_who.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
